// File: rtl/score_table_ctrl.sv
// score_table_ctrl: write-side sequencer for the game-over score table.
// Captures one score per game_over rising edge into a circular slot and
// runs a zero-fill sweep after reset or on request. It also keeps a
// registered best score and entry count. A one-deep pending slot absorbs
// events that arrive while the table port is busy.
module score_table_ctrl #(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 10,
    parameter int RESET_CLEAR = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              game_over,
    input  logic [DATA_W-1:0] score,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [DATA_W-1:0] best_score,
    output logic [ADDR_W:0]   entry_count,
    output logic              busy,
    output logic              write_ack,
    output logic              dropped
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam state_t          RESET_STATE = (RESET_CLEAR != 0) ? CLEAR : IDLE;
    localparam logic            RESET_BUSY  = (RESET_CLEAR != 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic                game_over_q;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                pending_q, pending_d;
    logic [DATA_W-1:0]   score_hold_q, score_hold_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0]   best_q, best_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                dropped_q, dropped_d;
    logic                edge_w;

    assign edge_w = game_over & ~game_over_q;

    // Next-state and next-output computation; every output is a flop loaded here.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        pending_d     = pending_q;
        score_hold_d  = score_hold_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        best_d        = best_q;
        count_d       = count_q;
        busy_d        = busy_q;
        ack_d         = 1'b0;
        dropped_d     = dropped_q;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d       = CLEAR;
                    busy_d        = 1'b1;
                    mem_wren_d    = 1'b1;
                    mem_address_d = '0;
                    mem_data_d    = '0;
                    best_d        = '0;
                    count_d       = '0;
                    wr_ptr_d      = '0;
                end else if (edge_w || pending_q) begin
                    state_d       = WRITE;
                    mem_wren_d    = 1'b1;
                    ack_d         = 1'b1;
                    mem_address_d = wr_ptr_q;
                    mem_data_d    = pending_q ? score_hold_q : score;
                    pending_d     = 1'b0;
                end
            end
            WRITE: begin
                // mem_data_q still carries the score being written, even if a
                // new edge overwrites score_hold in this same cycle.
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (count_q < FULL_CNT) begin
                    count_d = count_q + (ADDR_W + 1)'(1);
                end
                if (mem_data_q > best_q) begin
                    best_d = mem_data_q;
                end
                state_d = IDLE;
            end
            CLEAR: begin
                if (!mem_wren_q) begin
                    // First cycle out of reset: start the sweep at address 0.
                    mem_wren_d    = 1'b1;
                    mem_address_d = '0;
                    mem_data_d    = '0;
                    best_d        = '0;
                    count_d       = '0;
                    wr_ptr_d      = '0;
                end else if (mem_address_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    dropped_d = 1'b0;
                end else begin
                    mem_wren_d    = 1'b1;
                    mem_address_d = mem_address_q + ADDR_W'(1);
                    mem_data_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Events not served directly go to the one-deep pending slot; a second
        // one while it is full is lost and flagged (a late drop outlives a clear).
        if (edge_w) begin
            if (pending_q) begin
                dropped_d = 1'b1;
            end else if (state_q != IDLE || clear_req) begin
                pending_d    = 1'b1;
                score_hold_d = score;
            end else begin
                score_hold_d = score;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_STATE;
            game_over_q   <= 1'b0;
            wr_ptr_q      <= '0;
            pending_q     <= 1'b0;
            score_hold_q  <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            best_q        <= '0;
            count_q       <= '0;
            busy_q        <= RESET_BUSY;
            ack_q         <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            game_over_q   <= game_over;
            wr_ptr_q      <= wr_ptr_d;
            pending_q     <= pending_d;
            score_hold_q  <= score_hold_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            best_q        <= best_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            ack_q         <= ack_d;
            dropped_q     <= dropped_d;
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign best_score  = best_q;
    assign entry_count = count_q;
    assign busy        = busy_q;
    assign write_ack   = ack_q;
    assign dropped     = dropped_q;

endmodule
